// File: rtl/id_ex_skid.sv
// ID/EX pipeline register built as a two-entry skid buffer: main entry drives EX,
// skid entry absorbs one bundle of backpressure so in_ready depends only on state.
//
// state | meaning
// EMPTY | no bundle held, NOP bundle on out_*
// BUSY  | main holds the bundle presented to EX
// FULL  | main and skid both hold bundles, input stalled
module id_ex_skid #(
  parameter int DW   = 32,
  parameter int AW   = 5,
  parameter int OPW  = 8,
  parameter int SELW = 3,
  parameter int NSRC = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [OPW-1:0]       in_aluop,
  input  logic [SELW-1:0]      in_alusel,
  input  logic [NSRC*DW-1:0]   in_src,
  input  logic [AW-1:0]        in_wd,
  input  logic                 in_wreg,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OPW-1:0]       out_aluop,
  output logic [SELW-1:0]      out_alusel,
  output logic [NSRC*DW-1:0]   out_src,
  output logic [AW-1:0]        out_wd,
  output logic                 out_wreg,
  output logic [1:0]           occ
);

  localparam int BW = OPW + SELW + NSRC*DW + AW + 1;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [BW-1:0] main_q, skid_q, in_bundle;
  logic          in_fire, out_fire;
  logic          main_ld_in, main_ld_skid, main_clr, skid_ld, skid_clr;

  assign in_bundle = {in_aluop, in_alusel, in_src, in_wd, in_wreg};
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    main_ld_in   = 1'b0;
    main_ld_skid = 1'b0;
    main_clr     = 1'b0;
    skid_ld      = 1'b0;
    skid_clr     = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
      main_clr  = 1'b1;
      skid_clr  = 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            state_nxt  = BUSY;
            main_ld_in = 1'b1;
          end
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            main_ld_in = 1'b1;
          end else if (out_fire) begin
            state_nxt = EMPTY;
            main_clr  = 1'b1;
          end else if (in_fire) begin
            state_nxt = FULL;
            skid_ld   = 1'b1;
          end
        end
        FULL: begin
          if (out_fire) begin
            state_nxt    = BUSY;
            main_ld_skid = 1'b1;
            skid_clr     = 1'b1;
          end
        end
        default: begin
          state_nxt = EMPTY;
          main_clr  = 1'b1;
          skid_clr  = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    in_ready  = (state != FULL);
    out_valid = (state != EMPTY);
    occ       = state;
  end

  // Main is zeroed whenever it empties so EX sees a NOP bundle.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (main_clr)          main_q <= '0;
      else if (main_ld_skid) main_q <= skid_q;
      else if (main_ld_in)   main_q <= in_bundle;
      if (skid_clr)          skid_q <= '0;
      else if (skid_ld)      skid_q <= in_bundle;
    end
  end

  assign {out_aluop, out_alusel, out_src, out_wd, out_wreg} = main_q;

endmodule
